// File: rtl/smac_pkg.sv
// Shared types and width helpers for the systolic MAC accumulation path.
package smac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ac3_state_e;

   // Accumulator must hold M lane products summed over MNO operands.
   function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
      return $clog2(m) + pa + pw + $clog2(mno);
   endfunction

   function automatic int cnt_w(input int mno);
      return $clog2(mno + 1);
   endfunction

endpackage

// File: rtl/ac3_adder.sv
// Accumulator adder: partial sum from AC2 plus the running register value, wrapping.
module ac3_adder #(
   parameter int W = 29
) (
   input  logic [W-1:0] in_from_ac2,
   input  logic [W-1:0] in_from_reg,
   output logic [W-1:0] out_to_reg
);

   assign out_to_reg = in_from_ac2 + in_from_reg;

endmodule

// File: rtl/ac3_accum_ctrl.sv
// Accumulation controller: sums num_ops AC2 partial sums, quantizes by a logical
// right shift, then holds the result until the consumer takes it.
module ac3_accum_ctrl
   import smac_pkg::*;
#(
   parameter  int M   = 16,
   parameter  int Pa  = 8,
   parameter  int Pw  = 8,
   parameter  int MNO = 288,
   localparam int W   = acc_w(M, Pa, Pw, MNO),
   localparam int C   = cnt_w(MNO),
   localparam int SW  = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [C-1:0]  num_ops,
   input  logic [SW-1:0] shift_amt,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          busy
);

   ac3_state_e    state, state_d;
   logic [W-1:0]  acc, acc_sum;
   logic [C-1:0]  op_cnt, nops_q, nops_clamp;
   logic [SW-1:0] sh_cnt;
   logic          last_op;

   ac3_adder #(.W(W)) u_adder (
      .in_from_ac2 (in_data),
      .in_from_reg (acc),
      .out_to_reg  (acc_sum)
   );

   assign nops_clamp = (num_ops > C'(MNO)) ? C'(MNO) : num_ops;
   assign last_op    = (op_cnt + C'(1)) == nops_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (start) state_d = (nops_clamp == '0) ? SHIFT : ACC;
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && last_op) state_d = SHIFT;
         end
         // sh_cnt of 0 still costs one pass through SHIFT with no shift.
         SHIFT: if (sh_cnt <= SW'(1)) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            out_data  = acc;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc    <= '0;
         op_cnt <= '0;
         nops_q <= '0;
         sh_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               nops_q <= nops_clamp;
               sh_cnt <= shift_amt;
               acc    <= '0;
               op_cnt <= '0;
            end
            ACC: if (in_valid) begin
               acc    <= acc_sum;
               op_cnt <= op_cnt + C'(1);
            end
            SHIFT: if (sh_cnt != '0) begin
               acc    <= acc >> 1;
               sh_cnt <= sh_cnt - SW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ac3_accum_ctrl.sv
// Directed bench for ac3_accum_ctrl: hand-computed results and cycle latencies.
module tb_ac3_accum_ctrl;
   import smac_pkg::*;

   localparam int M   = 16;
   localparam int Pa  = 8;
   localparam int Pw  = 8;
   localparam int MNO = 288;
   localparam int W   = acc_w(M, Pa, Pw, MNO);
   localparam int C   = cnt_w(MNO);
   localparam int SW  = $clog2(W);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [C-1:0]  num_ops;
   logic [SW-1:0] shift_amt;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          busy;

   int checks = 0;
   int errors = 0;

   ac3_accum_ctrl #(.M(M), .Pa(Pa), .Pw(Pw), .MNO(MNO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_ops   (num_ops),
      .shift_amt (shift_amt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents start for one cycle; caller is then in cycle 1 of the job.
   task automatic start_job(input int n, input int s);
      start     = 1'b1;
      num_ops   = C'(n);
      shift_amt = SW'(s);
      step();
      start     = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(inout int cyc, output bit ok);
      while (!out_valid && cyc < 60) begin
         step();
         cyc++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%0b vld=%0b busy=%0b data=%0d exp all 0",
                  in_ready, out_valid, busy, out_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int cyc;
      bit ok;
      out_ready = 1'b1;
      start_job(3, 2);
      cyc = 1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_acc_entry got rdy=%0b busy=%0b exp 1 1", in_ready, busy);
      end
      feed(W'(10)); feed(W'(20)); feed(W'(30));
      cyc = 4;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_rdy_drop got %0b exp 0", in_ready);
      end
      wait_out(cyc, ok);
      checks++;
      if (!ok || cyc != 6) begin
         errors++;
         $display("FAIL basic_latency got %0d exp 6 (valid=%0b)", cyc, ok);
      end
      checks++;
      if (out_data !== W'(15)) begin
         errors++;
         $display("FAIL basic_data got %0d exp 15", out_data);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_release got vld=%0b busy=%0b exp 0 0", out_valid, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cyc;
      bit ok;
      start_job(3, 0);
      cyc = 1;
      feed(W'(5));
      in_valid = 1'b0; in_data = W'(100); step();
      feed(W'(7));
      in_valid = 1'b0; in_data = W'(200); step();
      feed(W'(9));
      cyc = 6;
      wait_out(cyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_timeout got out_valid=0 exp 1");
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== W'(21)) begin
            errors++;
            $display("FAIL bp_hold[%0d] got vld=%0b data=%0d exp 1 21", i, out_valid, out_data);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got vld=%0b busy=%0b exp 0 0", out_valid, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_zero();
      int cyc;
      bit ok;
      bit saw_rdy;
      in_valid = 1'b1;
      in_data  = W'(99);
      saw_rdy  = in_ready;
      start_job(0, 0);
      in_valid = 1'b1;
      cyc = 1;
      while (!out_valid && cyc < 60) begin
         saw_rdy |= in_ready;
         step();
         cyc++;
      end
      ok = out_valid;
      in_valid = 1'b0;
      checks++;
      if (!ok || cyc != 2) begin
         errors++;
         $display("FAIL zero_latency got %0d exp 2 (valid=%0b)", cyc, ok);
      end
      checks++;
      if (out_data !== '0 || saw_rdy !== 1'b0) begin
         errors++;
         $display("FAIL zero_data got data=%0d saw_rdy=%0b exp 0 0", out_data, saw_rdy);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int cyc;
      bit ok;
      logic [W-1:0] all1;
      all1 = '1;
      start_job(2, 0);
      cyc = 1;
      feed(all1);
      feed(W'(2));
      cyc = 3;
      wait_out(cyc, ok);
      checks++;
      if (!ok || out_data !== W'(1)) begin
         errors++;
         $display("FAIL wrap_data got %0d exp 1 (valid=%0b)", out_data, ok);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      int cyc;
      bit ok;
      start_job(1, 10);
      feed(W'(100));
      step();
      step();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_pre_shift got busy=%0b vld=%0b exp 1 0", busy, out_valid);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
         errors++;
         $display("FAIL rst_mid_shift got rdy=%0b vld=%0b busy=%0b data=%0d exp all 0",
                  in_ready, out_valid, busy, out_data);
      end
      rst_n = 1'b1;
      start_job(1, 3);
      cyc = 1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_first_start got rdy=%0b exp 1", in_ready);
      end
      feed(W'(8));
      cyc = 2;
      wait_out(cyc, ok);
      checks++;
      if (!ok || cyc != 5 || out_data !== W'(1)) begin
         errors++;
         $display("FAIL rst_next_job got cyc=%0d data=%0d exp 5 1", cyc, out_data);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_ignored_start();
      int cyc;
      bit ok;
      start_job(2, 1);
      feed(W'(40));
      start     = 1'b1;
      num_ops   = C'(5);
      shift_amt = SW'(0);
      feed(W'(60));
      start = 1'b0;
      cyc = 3;
      wait_out(cyc, ok);
      checks++;
      if (!ok || cyc != 4 || out_data !== W'(50)) begin
         errors++;
         $display("FAIL ignored_start got cyc=%0d data=%0d exp 4 50", cyc, out_data);
      end
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_on_release got busy=%0b vld=%0b exp 0 0", busy, out_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      num_ops   = '0;
      shift_amt = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero();
      test_wrap();
      test_reset_mid_shift();
      test_ignored_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
